// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core pipeline.
// Holds the architectural widths and the register address type.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file.sv
// Integer register file x0..x31: two combinational read ports, one write port.
// x0 has no storage and always reads zero.
module register_file
    import core_pkg::*;
#(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  reg_addr_t       rs1_addr,
    input  reg_addr_t       rs2_addr,
    input  reg_addr_t       rd_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            wr_en,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [1:NREG-1];

    logic wr_hit;
    assign wr_hit = wr_en && (rd_addr != REG_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[rd_addr[AW-1:0]] <= wr_data;
        end
    end

    // Reset also masks the write-through path so every read is zero.
    function automatic logic [XLEN-1:0] read_port(input reg_addr_t a);
        logic [XLEN-1:0] v;
        v = '0;
        if (!rst_n || a == REG_ZERO) begin
            v = '0;
        end else if (BYPASS != 0 && wr_hit && rd_addr == a) begin
            v = wr_data;
        end else begin
            v = regs[a[AW-1:0]];
        end
        return v;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file.
// Expected read values come from a reference array kept by the bench.
module tb_register_file;
    import core_pkg::*;

    logic        clk;
    logic        rst_n;
    reg_addr_t   rs1_addr;
    reg_addr_t   rs2_addr;
    reg_addr_t   rd_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    register_file #(
        .XLEN(32),
        .NREG(32),
        .BYPASS(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rd_addr(rd_addr),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m[32];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input reg_addr_t a);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (wr_en && rd_addr != 5'd0 && rd_addr == a) return wr_data;
        return m[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
    endtask

    task automatic rd(input reg_addr_t a1, input reg_addr_t a2,
                      input string tag);
        exp_t e;
        rs1_addr = a1;
        rs2_addr = a2;
        sbq.push_back('{tag, exp_rd(a1), exp_rd(a2)});
        #1;
        e = sbq.pop_front();
        chk({e.tag, ".rs1"}, rs1_data, e.e1);
        chk({e.tag, ".rs2"}, rs2_data, e.e2);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic wr(input reg_addr_t a, input logic [31:0] d);
        rd_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk);
        if (rst_n && a != 5'd0) m[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd(reg_addr_t'(i), reg_addr_t'(31 - i), tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rd_addr  = '0;
        wr_data  = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rd(5'd0, 5'd0, "rst_x0");
        rd(5'd1, 5'd31, "rst_val");
        rst_n = 1'b1;

        wr(5'd0, 32'hDEADBEEF);
        rd(5'd0, 5'd0, "x0_wr");

        wr(5'd1, 32'h12345678);
        wr(5'd10, 32'hABCDEF01);
        wr(5'd31, 32'hFFFFFFFF);
        rd(5'd1, 5'd10, "wr_a");
        rd(5'd31, 5'd31, "wr_b");
        chk("x31_direct", m[31], 32'hFFFFFFFF);

        wr(5'd5, 32'h11111111);
        rd(5'd5, 5'd5, "ow1");
        wr(5'd5, 32'h22222222);
        rd(5'd5, 5'd5, "ow2");
        wr(5'd5, 32'h0);
        rd(5'd5, 5'd5, "ow3");

        wr(5'd2, 32'hAAAAAAAA);
        wr(5'd3, 32'h55555555);
        rd(5'd2, 5'd3, "dual");
        rd(5'd0, 5'd1, "dual_x0");
        rd(5'd10, 5'd10, "same");

        for (int i = 1; i < 32; i++) begin
            wr(reg_addr_t'(i), 32'h10000000 + i);
        end
        sweep("sweep");

        wr(5'd7, 32'h77777777);
        rd_addr = 5'd7;
        wr_data = 32'h99999999;
        wr_en   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rd(5'd7, 5'd7, "wen0");

        wr(5'd15, 32'hFEDCBA98);
        rd(5'd15, 5'd1, "pre_rst");
        rst_n = 1'b0;
        model_clear();
        rd(5'd15, 5'd1, "rst_pulse");
        rd_addr = 5'd3;
        wr_data = 32'hCAFEF00D;
        wr_en   = 1'b1;
        rd(5'd3, 5'd3, "rst_nobyp");
        repeat (2) @(negedge clk);
        wr_en = 1'b0;
        sweep("rst_all");
        rst_n = 1'b1;

        wr(5'd9, 32'h13572468);
        rd(5'd9, 5'd9, "post_rst");

        #2;
        rst_n = 1'b0;
        model_clear();
        rd(5'd9, 5'd9, "async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        rd(5'd9, 5'd9, "async_hold");

        for (int i = 0; i < 5; i++) begin
            wr(5'd20, 32'hA0000000 + i);
        end
        rd(5'd20, 5'd20, "b2b");

        rd_addr = 5'd20;
        wr_data = 32'hBEEF0020;
        wr_en   = 1'b1;
        rd(5'd20, 5'd20, "bypass");
        rd(5'd20, 5'd21, "byp_other");
        @(posedge clk);
        m[20] = 32'hBEEF0020;
        @(negedge clk);
        wr_en = 1'b0;
        rd(5'd20, 5'd0, "byp_commit");

        if (sbq.size() != 0) chk("sbq_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
